// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: requester-side controller for a 1RW+1R OpenRAM macro.
//   clk, rst             : single clock (also the macro's clk0/clk1), async active-high reset
//   a_*                  : port-A read/write request channel, drives macro port 0
//   a_rsp_*              : port-A read response channel (valid/ready)
//   b_*                  : port-B read-only request channel, drives macro port 1
//   b_rsp_*              : port-B read response channel (valid/ready)
//   sram_*0 / sram_*1    : macro port-0 / port-1 signals
// Reads are issued at handshake edge N, macro dout is captured at edge N+1 into a
// per-port response FIFO. A read is accepted only when a buffer slot is guaranteed.
module sram_1rw1r_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);

  logic                  a_issue;
  logic                  b_issue;
  logic                  collide;
  logic [1:0]            rd_issue;
  logic [1:0]            rsp_rdy;
  logic [1:0]            rsp_vld;
  logic [1:0]            credit;
  logic [DATA_WIDTH-1:0] dout  [2];
  logic [DATA_WIDTH-1:0] rdata [2];

  // A same-address write on port A wins over a port-B read in the same cycle.
  assign collide = a_valid && a_we && (a_addr == b_addr);

  assign a_ready = !rst && (a_we || credit[0]);
  assign b_ready = !rst && credit[1] && !collide;
  assign a_issue = a_valid && a_ready;
  assign b_issue = b_valid && b_ready;

  assign sram_csb0   = !a_issue;
  assign sram_web0   = !(a_issue && a_we);
  assign sram_wmask0 = (a_issue && a_we) ? a_wmask : '0;
  assign sram_addr0  = a_addr;
  assign sram_din0   = a_wdata;
  assign sram_csb1   = !b_issue;
  assign sram_addr1  = b_addr;

  assign rd_issue = {b_issue, a_issue && !a_we};
  assign rsp_rdy  = {b_rsp_ready, a_rsp_ready};
  assign dout[0]  = sram_dout0;
  assign dout[1]  = sram_dout1;

  assign a_rsp_valid = rsp_vld[0];
  assign b_rsp_valid = rsp_vld[1];
  assign a_rsp_data  = rdata[0];
  assign b_rsp_data  = rdata[1];

  for (genvar p = 0; p < 2; p++) begin : g_rsp
    logic                  inflight;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] buf_mem [RSP_DEPTH];
    logic                  pop;
    logic [CW:0]           used;
    logic [CW:0]           limit;

    assign rsp_vld[p] = (count != '0);
    assign rdata[p]   = buf_mem[rd_ptr];
    assign pop        = rsp_vld[p] && rsp_rdy[p];

    // occupancy + inflight - pop < RSP_DEPTH, rearranged to stay unsigned.
    assign used     = {1'b0, count} + (CW+1)'(inflight);
    assign limit    = (CW+1)'(RSP_DEPTH) + (CW+1)'(pop);
    assign credit[p] = (used < limit);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        inflight <= 1'b0;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
          buf_mem[i] <= '0;
        end
      end else begin
        inflight <= rd_issue[p];
        // Macro dout is only valid on the edge right after issue.
        if (inflight) begin
          buf_mem[wr_ptr] <= dout[p];
          wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
        if (inflight && !pop) begin
          count <= count + 1'b1;
        end else if (!inflight && pop) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl: bench for sram_1rw1r_ctrl with a behavioural 1RW+1R macro
// and a transaction-level reference (memory array + expected response queues).
module tb_sram_1rw1r_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NM = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, a_we;
  logic [NM-1:0] a_wmask;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_rsp_valid, a_rsp_ready;
  logic [DW-1:0] a_rsp_data;
  logic          b_valid, b_ready;
  logic [AW-1:0] b_addr;
  logic          b_rsp_valid, b_rsp_ready;
  logic [DW-1:0] b_rsp_data;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [NM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;

  always #5 clk = ~clk;

  sram_1rw1r_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Behavioural macro: reads sampled at posedge, writes land on the negedge,
  // dout carries garbage whenever no read was issued on the previous edge.
  logic [DW-1:0] sram_mem [1024];
  logic          wr_pend = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NM-1:0] wr_mask;

  always @(posedge clk) begin
    sram_dout0 <= (!sram_csb0 && sram_web0) ? sram_mem[sram_addr0] : $urandom;
    sram_dout1 <= (!sram_csb1) ? sram_mem[sram_addr1] : $urandom;
    wr_pend <= !sram_csb0 && !sram_web0;
    wr_addr <= sram_addr0;
    wr_data <= sram_din0;
    wr_mask <= sram_wmask0;
  end

  always @(negedge clk) begin
    if (wr_pend) begin
      for (int k = 0; k < NM; k++) begin
        if (wr_mask[k]) sram_mem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
      end
    end
  end

  // Reference model
  logic [DW-1:0] mem_ref [1024];
  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];
  int  lf_a = 0, lf_b = 0;
  int  errors = 0, checks = 0;
  bit  last_hs_a, last_hs_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check all outputs at the negedge, then account for the edge.
  task automatic cycle();
    bit ea_v, eb_v, ea_r, eb_r, pop_a, pop_b, coll, hs_a, hs_b;
    @(negedge clk);
    ea_v  = (q_a.size() > lf_a);
    eb_v  = (q_b.size() > lf_b);
    pop_a = ea_v && a_rsp_ready;
    pop_b = eb_v && b_rsp_ready;
    coll  = a_valid && a_we && (a_addr == b_addr);
    ea_r  = a_we || ((int'(q_a.size()) - int'(pop_a)) < DEPTH);
    eb_r  = !coll && ((int'(q_b.size()) - int'(pop_b)) < DEPTH);
    chk("a_rsp_valid", a_rsp_valid, ea_v);
    chk("b_rsp_valid", b_rsp_valid, eb_v);
    if (ea_v) chk("a_rsp_data", a_rsp_data, q_a[0]);
    if (eb_v) chk("b_rsp_data", b_rsp_data, q_b[0]);
    chk("a_ready", a_ready, ea_r);
    chk("b_ready", b_ready, eb_r);
    chk("sram_csb0", sram_csb0, !(a_valid && ea_r));
    chk("sram_csb1", sram_csb1, !(b_valid && eb_r));
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
    last_hs_a = hs_a;
    last_hs_b = hs_b;
    @(posedge clk);
    if (pop_a) void'(q_a.pop_front());
    if (pop_b) void'(q_b.pop_front());
    lf_a = 0;
    lf_b = 0;
    if (hs_b) begin q_b.push_back(mem_ref[b_addr]); lf_b = 1; end
    if (hs_a && !a_we) begin q_a.push_back(mem_ref[a_addr]); lf_a = 1; end
    if (hs_a && a_we) begin
      for (int k = 0; k < NM; k++) begin
        if (a_wmask[k]) mem_ref[a_addr][8*k +: 8] = a_wdata[8*k +: 8];
      end
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = $urandom;
      mem_ref[i]  = sram_mem[i];
    end
    rst = 1'b1;
    a_valid = 1'b1; a_we = 1'b1; a_wmask = '1; a_addr = '0; a_wdata = '0;
    b_valid = 1'b1; b_addr = '0;
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    chk("rst_csb0", sram_csb0, 1);
    chk("rst_csb1", sram_csb1, 1);
    chk("rst_web0", sram_web0, 1);
    chk("rst_wmask0", sram_wmask0, 0);
    chk("rst_a_rsp_data", a_rsp_data, 0);
    chk("rst_b_rsp_data", b_rsp_data, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;

    // Write then read-after-write on port A, 1-cycle latency
    a_valid = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 32'hDEADBEEF; a_wmask = 4'hF;
    cycle();
    a_we = 1'b0;
    cycle();
    a_valid = 1'b0;
    chk("t1_not_yet_valid", a_rsp_valid, 0);
    cycle();
    chk("t1_valid", a_rsp_valid, 1);
    chk("t1_data", a_rsp_data, 32'hDEADBEEF);
    a_rsp_ready = 1'b1;
    cycle();

    // Partial write, read back on port B
    a_valid = 1'b1; a_we = 1'b1; a_wdata = 32'h11223344; a_wmask = 4'h5;
    cycle();
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 10'h005;
    cycle();
    b_valid = 1'b0;
    cycle();
    chk("t2_data", b_rsp_data, 32'hDE22BE44);
    b_rsp_ready = 1'b1;
    cycle();

    // Same-address collision: A write wins, B retries next cycle
    a_valid = 1'b1; a_we = 1'b1; a_addr = 10'h3FF; a_wdata = 32'hCAFEF00D; a_wmask = 4'hF;
    b_valid = 1'b1; b_addr = 10'h3FF; b_rsp_ready = 1'b0;
    cycle();
    chk("t3_blocked", last_hs_b, 0);
    a_valid = 1'b0;
    cycle();
    chk("t3_retry", last_hs_b, 1);
    b_valid = 1'b0;
    cycle();
    chk("t3_data", b_rsp_data, 32'hCAFEF00D);
    b_rsp_ready = 1'b1;
    cycle();

    // Back-to-back B reads 0x000..0x00F
    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1; b_addr = AW'(i);
      cycle();
      if (last_hs_b) nacc++;
    end
    chk("t4_accepts", nacc, 16);
    b_valid = 1'b0;
    repeat (2) cycle();

    // A reads with consumer stalled: exactly DEPTH accepted
    a_rsp_ready = 1'b0; a_valid = 1'b1; a_we = 1'b0; a_addr = 10'h010;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_hs_a) begin nacc++; a_addr = a_addr + 1'b1; end
    end
    chk("t5_accepts", nacc, DEPTH);
    a_valid = 1'b0; a_rsp_ready = 1'b1;
    repeat (4) cycle();

    // Reset with full A buffer and B read in flight
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 10'h020;
    repeat (3) cycle();
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 10'h021;
    cycle();
    a_valid = 1'b1; b_addr = 10'h022;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_csb0", sram_csb0, 1);
    chk("t6_csb1", sram_csb1, 1);
    chk("t6_a_rsp_valid", a_rsp_valid, 0);
    chk("t6_b_rsp_valid", b_rsp_valid, 0);
    q_a.delete(); q_b.delete(); lf_a = 0; lf_b = 0;
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("t6_no_stale_a", a_rsp_valid, 0);
    chk("t6_no_stale_b", b_rsp_valid, 0);

    // Randomized traffic over a small address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      a_valid = 1'($urandom);
      a_we = 1'($urandom);
      a_addr = AW'($urandom_range(0, 15));
      a_wdata = $urandom;
      a_wmask = NM'($urandom);
      b_valid = 1'($urandom);
      b_addr = AW'($urandom_range(0, 15));
      a_rsp_ready = ($urandom_range(0, 9) < 7);
      b_rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    a_valid = 1'b0; b_valid = 1'b0; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_a", a_rsp_valid, 0);
    chk("drain_b", b_rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_1rw1r_ctrl.md
Name: sram_1rw1r_ctrl

Overview:
- Requester-side controller for the 1RW+1R OpenRAM SRAM macros (for example the 32x1024, wmask-8 macro).
- Converts two valid/ready request channels into macro port signals.
  - Channel A is read/write and maps to macro port 0.
  - Channel B is read-only and maps to macro port 1.
- Captures macro read data on the posedge after issue and returns it through per-port response buffers with backpressure.
- Sits between the bus fabric and the macro. Clocks clk0 and clk1 of the macro are both tied to this block's clk.

Parameters:
- ADDR_WIDTH, 10, word address width.
- DATA_WIDTH, 32, data width.
- NUM_WMASKS, 4, byte write-mask width (DATA_WIDTH/8).
- RSP_DEPTH, 2, entries per response buffer (minimum 2).

Ports:
- clk  in  1  single clock for the block and both macro ports.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  port-A request valid.
- a_ready  out  1  port-A request ready.
- a_we  in  1  1=write, 0=read.
- a_wmask  in  NUM_WMASKS  byte enables for writes.
- a_addr  in  ADDR_WIDTH  port-A address.
- a_wdata  in  DATA_WIDTH  port-A write data.
- a_rsp_valid  out  1  port-A read data valid.
- a_rsp_ready  in  1  port-A read data accepted.
- a_rsp_data  out  DATA_WIDTH  port-A read data.
- b_valid  in  1  port-B read request valid.
- b_ready  out  1  port-B request ready.
- b_addr  in  ADDR_WIDTH  port-B address.
- b_rsp_valid  out  1  port-B read data valid.
- b_rsp_ready  in  1  port-B read data accepted.
- b_rsp_data  out  DATA_WIDTH  port-B read data.
- sram_csb0  out  1  macro port-0 chip select, active low.
- sram_web0  out  1  macro port-0 write enable, active low.
- sram_wmask0  out  NUM_WMASKS  macro port-0 write mask.
- sram_addr0  out  ADDR_WIDTH  macro port-0 address.
- sram_din0  out  DATA_WIDTH  macro port-0 write data.
- sram_dout0  in  DATA_WIDTH  macro port-0 read data.
- sram_csb1  out  1  macro port-1 chip select, active low.
- sram_addr1  out  ADDR_WIDTH  macro port-1 address.
- sram_dout1  in  DATA_WIDTH  macro port-1 read data.

Behaviour:
- The block has one clock and an asynchronous, active-high reset (clk, rst).
- Reset values:
  - a_ready=0, b_ready=0, a_rsp_valid=0, b_rsp_valid=0.
  - sram_csb0=1, sram_csb1=1, sram_web0=1, sram_wmask0=0.
  - Response buffers are empty, in-flight flags are 0, and response data is 0.
- Macro drive is combinational from the handshake:
  - sram_csb0 = !(a_valid && a_ready).
  - sram_web0 = !a_we when selected, 1 when idle.
  - sram_wmask0 = a_wmask on writes, 0 otherwise.
  - sram_addr0, sram_din0 and sram_addr1 pass through from the request channels.
  - sram_csb1 = !(b_valid && b_ready).
  - The macro samples these at the handshake edge N.
- Read latency:
  - An in-flight flag is set at edge N.
  - sram_doutX is captured into the response buffer at edge N+1, when the flag clears.
  - rsp_valid is high from edge N+1, so handshake to rsp_valid is 1 cycle.
  - No capture occurs at any other edge, because macro dout goes X shortly after each posedge.
- Credit rule: per port, a read is accepted only if (occupancy + inflight − rsp_pop) < RSP_DEPTH, where rsp_pop = rsp_valid && rsp_ready in the current cycle.
  - This sustains 1 read per cycle while the consumer holds rsp_ready=1.
  - A captured word is never dropped.
- Port-A writes:
  - Ready does not depend on credits; a_ready=1 for writes whenever rst=0.
  - Writes produce no response.
  - A write and a read of the same address in consecutive cycles returns the written data. The macro writes on the negedge, before the next read samples.
- Collision: if port-A writes and port-B reads the same address in the same cycle, A has priority and b_ready=0 that cycle. B retries the next cycle.
- Response buffers:
  - FIFO order, RSP_DEPTH entries per port.
  - rsp_data is stable while rsp_valid=1 and rsp_ready=0.
  - Capture and pop on the same edge are allowed, and occupancy is unchanged.
- Ports A and B are fully independent apart from the collision rule.
- Reset asserted mid-operation:
  - csb outputs go to 1 immediately (asynchronous).
  - In-flight reads are discarded and buffers are cleared.
  - No response is emitted for requests issued before reset.

Test Plan:
- Reset, then A writes addr 0x005 data 0xDEADBEEF wmask 0xF, then A reads 0x005 in the next cycle → a_rsp_valid exactly 1 cycle after the read handshake with data 0xDEADBEEF.
- Partial write of 0x11223344 with wmask 0x5 over 0xDEADBEEF at 0x005, then B reads 0x005 → b_rsp_data 0xDE22BE44.
- A writes 0x3FF while B reads 0x3FF in the same cycle → b_ready=0 that cycle; B is accepted the next cycle and returns the new data.
- Back-to-back B reads 0x000 to 0x00F with b_rsp_ready=1 → 16 responses on consecutive cycles, in order.
- Back-to-back A reads with a_rsp_ready=0 → exactly RSP_DEPTH accepted, then a_ready=0. Release rsp_ready → data is returned in order with none lost.
- Assert rst with a read in flight and a full buffer → csb high immediately, rsp_valid=0, no stale response after reset release.
